// File: rtl/barrido_entrada_param_if.sv
// Keypad-entry / frame-consumer bus for barrido_entrada_param.
// master: keypad decoder + ALU consumer side; slave: the scan/entry block.
interface barrido_entrada_param_if #(
  parameter int unsigned N_DIGITS = 8
);
  logic                    key_valid;
  logic [6:0]              key_seg;
  logic                    key_is_digit;
  logic                    key_bksp;
  logic                    clr;
  logic [7*N_DIGITS-1:0]   frame;
  logic                    done;
  logic                    full;
  logic                    reject;

  modport master (
    output key_valid, key_seg, key_is_digit, key_bksp, clr,
    input  frame, done, full, reject
  );

  modport slave (
    input  key_valid, key_seg, key_is_digit, key_bksp, clr,
    output frame, done, full, reject
  );
endinterface

// File: rtl/barrido_entrada_param.sv
// Seven-segment scan plus keypad operand/operator entry with registered frame/done.
// Optional cursor blink enabled by defining BARRIDO_BLINK_EN.
module barrido_entrada_param #(
  parameter int unsigned          N_DIGITS   = 8,
  parameter logic [N_DIGITS-1:0]  TYPE_MASK  = 8'b0111_0111,
  parameter logic [6:0]           BLANK_CODE = 7'b1101100,
  parameter int unsigned          SCAN_DIV   = 1,
  parameter int unsigned          BLINK_DIV  = 250
) (
  input  logic                  clk1kHz,
  input  logic                  rst_n,
  barrido_entrada_param_if.slave bus,
  output logic [6:0]            Sseg,
  output logic [N_DIGITS-1:0]   anodos
);
  localparam int unsigned   PW      = $clog2(N_DIGITS);
  localparam int unsigned   DW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PTR_TOP = PW'(N_DIGITS - 1);
  localparam logic [6:0]    BLANK   = 7'h7F;

  if (N_DIGITS < 2 || N_DIGITS > 16 || SCAN_DIV == 0 || BLINK_DIV == 0) begin : g_param_check
    $error("barrido_entrada_param: parameter out of range");
  end

  logic [6:0]            digit [N_DIGITS];
  logic [PW-1:0]         ptr, idx, idx_next;
  logic [DW-1:0]         div;
  logic                  full_q, done_q, reject_q;
  logic [7*N_DIGITS-1:0] frame_q, frame_next;
  logic                  scan_tick, key_ok, do_clr, do_bksp, do_key;
  logic [6:0]            key_store, sseg_next;

`ifdef BARRIDO_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic          phase;
  logic [BW-1:0] bcnt;

  always_ff @(posedge clk1kHz or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b1;
      bcnt  <= '0;
    end else if (bcnt == BW'(BLINK_DIV - 1)) begin
      phase <= ~phase;
      bcnt  <= '0;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end
`endif

  always_comb begin
    scan_tick = (div == DW'(SCAN_DIV - 1));
    idx_next  = (idx == PTR_TOP) ? '0 : idx + 1'b1;
    sseg_next = digit[idx_next];
`ifdef BARRIDO_BLINK_EN
    if (!full_q && idx_next == ptr && !phase) sseg_next = BLANK;
`endif
    do_clr    = bus.clr;
    do_bksp   = !bus.clr && bus.key_bksp;
    do_key    = !bus.clr && !bus.key_bksp && bus.key_valid;
    key_ok    = !full_q && (bus.key_is_digit == TYPE_MASK[ptr]);
    // a blank-code symbol (implicit '+') is stored as an unlit digit
    key_store = (!bus.key_is_digit && bus.key_seg == BLANK_CODE) ? BLANK : bus.key_seg;
    frame_next = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      frame_next[7*i +: 7] = (i == 0) ? key_store : digit[PW'(i)];
    end
  end

  always_ff @(posedge clk1kHz or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      idx    <= '0;
      Sseg   <= BLANK;
      anodos <= '1;
    end else if (scan_tick) begin
      div    <= '0;
      idx    <= idx_next;
      anodos <= ~(N_DIGITS'(1) << idx_next);
      Sseg   <= sseg_next;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk1kHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_DIGITS; i++) digit[i] <= BLANK;
      ptr      <= PTR_TOP;
      full_q   <= 1'b0;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
      frame_q  <= '1;
    end else begin
      done_q   <= 1'b0;
      reject_q <= 1'b0;
      if (do_clr) begin
        for (int unsigned i = 0; i < N_DIGITS; i++) digit[i] <= BLANK;
        ptr    <= PTR_TOP;
        full_q <= 1'b0;
      end else if (do_bksp) begin
        if (!full_q && ptr < PTR_TOP) begin
          ptr                <= ptr + 1'b1;
          digit[ptr + 1'b1]  <= BLANK;
        end
      end else if (do_key) begin
        if (key_ok) begin
          digit[ptr] <= key_store;
          if (ptr == '0) begin
            frame_q <= frame_next;
            done_q  <= 1'b1;
            full_q  <= 1'b1;
          end else begin
            ptr <= ptr - 1'b1;
          end
        end else begin
          reject_q <= 1'b1;
        end
      end
    end
  end

  assign bus.frame  = frame_q;
  assign bus.done   = done_q;
  assign bus.full   = full_q;
  assign bus.reject = reject_q;
endmodule

// File: tb/tb_barrido_entrada_param.sv
// Directed bench for barrido_entrada_param: cycle model of scan/entry plus frame scoreboard.
module tb_barrido_entrada_param;
  localparam int unsigned N      = 8;
  localparam logic [7:0]  TM     = 8'b0111_0111;
  localparam logic [6:0]  BLANKC = 7'b1101100;
`ifdef BARRIDO_BLINK_EN
  localparam int unsigned BD = 4;
`else
  localparam int unsigned BD = 250;
`endif

  logic           clk1kHz = 1'b0;
  logic           rst_n   = 1'b0;
  logic [6:0]     Sseg;
  logic [N-1:0]   anodos;

  barrido_entrada_param_if #(.N_DIGITS(N)) bus ();

  barrido_entrada_param #(
    .N_DIGITS(N), .TYPE_MASK(TM), .BLANK_CODE(BLANKC), .SCAN_DIV(1), .BLINK_DIV(BD)
  ) dut (
    .clk1kHz(clk1kHz), .rst_n(rst_n), .bus(bus), .Sseg(Sseg), .anodos(anodos)
  );

  always #5 clk1kHz = ~clk1kHz;

  int checks = 0;
  int errors = 0;

  logic [6:0]     m_dig [N];
  int unsigned    m_ptr, m_idx, m_bcnt;
  logic           m_full, m_phase;
  logic [6:0]     e_sseg;
  logic [N-1:0]   e_an;
  logic           e_done, e_rej;
  logic [7*N-1:0] m_frame;
  logic [7*N-1:0] sb [$];
  logic [7*N-1:0] frame_a;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_dig[i] = 7'h7F;
    m_ptr = N - 1; m_idx = 0; m_full = 1'b0; m_frame = '1;
    m_bcnt = 0; m_phase = 1'b1;
    e_sseg = 7'h7F; e_an = '1; e_done = 1'b0; e_rej = 1'b0;
    sb.delete();
  endtask

  task automatic compare_all();
    check("anodos", 64'(anodos), 64'(e_an));
    check("Sseg", 64'(Sseg), 64'(e_sseg));
    check("done", 64'(bus.done), 64'(e_done));
    check("reject", 64'(bus.reject), 64'(e_rej));
    check("full", 64'(bus.full), 64'(m_full));
    check("frame", 64'(bus.frame), 64'(m_frame));
    if (bus.done && sb.size() > 0) check("sb_frame", 64'(bus.frame), 64'(sb.pop_front()));
  endtask

  task automatic tick();
    int unsigned nxt;
    @(posedge clk1kHz);
    nxt = (m_idx == N - 1) ? 0 : m_idx + 1;
    e_an = '1;
    e_an[nxt] = 1'b0;
    e_sseg = m_dig[nxt];
`ifdef BARRIDO_BLINK_EN
    if (!m_full && nxt == m_ptr && !m_phase) e_sseg = 7'h7F;
    if (m_bcnt == BD - 1) begin m_bcnt = 0; m_phase = !m_phase; end
    else m_bcnt++;
`endif
    m_idx = nxt;
    e_done = 1'b0;
    e_rej  = 1'b0;
    if (bus.clr) begin
      for (int i = 0; i < N; i++) m_dig[i] = 7'h7F;
      m_ptr = N - 1; m_full = 1'b0;
    end else if (bus.key_bksp) begin
      if (!m_full && m_ptr < N - 1) begin
        m_ptr++;
        m_dig[m_ptr] = 7'h7F;
      end
    end else if (bus.key_valid) begin
      if (!m_full && bus.key_is_digit == TM[m_ptr]) begin
        m_dig[m_ptr] = (!bus.key_is_digit && bus.key_seg == BLANKC) ? 7'h7F : bus.key_seg;
        if (m_ptr == 0) begin
          for (int i = 0; i < N; i++) m_frame[7*i +: 7] = m_dig[i];
          sb.push_back(m_frame);
          e_done = 1'b1;
          m_full = 1'b1;
        end else begin
          m_ptr--;
        end
      end else begin
        e_rej = 1'b1;
      end
    end
    #1;
    bus.key_valid = 1'b0; bus.key_bksp = 1'b0; bus.clr = 1'b0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic key(input logic [6:0] s, input logic d);
    bus.key_valid = 1'b1; bus.key_seg = s; bus.key_is_digit = d;
    tick();
  endtask

  task automatic bksp();
    bus.key_bksp = 1'b1;
    tick();
  endtask

  task automatic clear();
    bus.clr = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.key_valid = 1'b0; bus.key_seg = '0; bus.key_is_digit = 1'b0;
    bus.key_bksp = 1'b0; bus.clr = 1'b0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk1kHz);
    rst_n = 1'b1;
    idle(16);

    // full entry: sign, three digits, operator, three digits
    key(7'h3F, 1'b0); key(7'h79, 1'b1); key(7'h24, 1'b1); key(7'h30, 1'b1);
    key(7'h0C, 1'b0); key(7'h19, 1'b1); key(7'h12, 1'b1); key(7'h02, 1'b1);
    frame_a = {7'h3F, 7'h79, 7'h24, 7'h30, 7'h0C, 7'h19, 7'h12, 7'h02};
    check("frame_literal", 64'(bus.frame), 64'(frame_a));
    idle(2);

    // locked when full; clr beats a same-cycle key
    key(7'h19, 1'b1);
    key(7'h0C, 1'b0);
    bus.clr = 1'b1;
    key(7'h19, 1'b1);
    idle(9);
    check("frame_kept", 64'(bus.frame), 64'(frame_a));

    // blank code at a symbol position, then a type mismatch
    key(BLANKC, 1'b0);
    key(7'h0C, 1'b0);
    key(7'h79, 1'b1);
    key(7'h24, 1'b1);
    bksp();
    idle(8);
    key(7'h30, 1'b1);
    bus.key_bksp = 1'b1;
    key(7'h12, 1'b1);
    clear();
    bksp();
    idle(9);

    // async reset in the middle of an entry
    key(7'h3F, 1'b0); key(7'h79, 1'b1); key(7'h24, 1'b1); key(7'h30, 1'b1);
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk1kHz);
    rst_n = 1'b1;
    idle(10);

    // second complete frame after reset
    key(BLANKC, 1'b0); key(7'h40, 1'b1); key(7'h79, 1'b1); key(7'h24, 1'b1);
    key(7'h3F, 1'b0); key(7'h30, 1'b1); key(7'h19, 1'b1); key(7'h12, 1'b1);
    idle(10);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
